// File: rtl/change_dispenser.sv
// change_dispenser: pays out a latched change amount one coin at a time,
// greedy largest-denomination first, using a req/ack handshake with the hopper.
// A hopper that never acknowledges latches a sticky ERR that only reset clears.
//
//   state  | meaning
//   S_IDLE | waiting for ACT_IN; a zero amount completes immediately
//   S_REQ  | COIN_REQ high, COIN_SEL stable, waiting for COIN_ACK or timeout
//   S_GAP  | one idle cycle between coins, next coin selected
//   S_FIN  | DONE pulse cycle, then back to IDLE
//   S_ERR  | hopper stalled; frozen until reset
module change_dispenser #(
  parameter int WIDTH   = 4,
  parameter int DEN_HI  = 5,
  parameter int DEN_MID = 2,
  parameter int DEN_LO  = 1,
  parameter int TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             RD,
  input  logic             ACT_IN,
  input  logic [WIDTH-1:0] CHANGE_IN,
  input  logic             COIN_ACK,
  output logic             COIN_REQ,
  output logic [1:0]       COIN_SEL,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [WIDTH-1:0] REMAIN,
  output logic [WIDTH-1:0] COIN_CNT
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_GAP, S_FIN, S_ERR} state_t;

  // Timer counts down from TIMEOUT-1; reaching zero without ack is the last allowed REQ cycle.
  localparam int               TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]    TO_LOAD = TW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] W_HI    = WIDTH'(DEN_HI);
  localparam logic [WIDTH-1:0] W_MID   = WIDTH'(DEN_MID);
  localparam logic [WIDTH-1:0] W_LO    = WIDTH'(DEN_LO);

  function automatic logic [1:0] f_sel(input logic [WIDTH-1:0] amt);
    if (amt >= W_HI)       return 2'b11;
    else if (amt >= W_MID) return 2'b10;
    else if (amt >= W_LO)  return 2'b01;
    else                   return 2'b00;
  endfunction

  function automatic logic [WIDTH-1:0] f_den(input logic [1:0] sel);
    case (sel)
      2'b11:   return W_HI;
      2'b10:   return W_MID;
      2'b01:   return W_LO;
      default: return '0;
    endcase
  endfunction

  state_t           r_state, w_state_nxt;
  logic [TW-1:0]    r_timer, w_timer_nxt;
  logic             r_req, w_req_nxt;
  logic [1:0]       r_sel, w_sel_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic [WIDTH-1:0] r_remain, w_remain_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] w_rem_after;

  // COIN_SEL is always a denomination no larger than REMAIN, so this cannot underflow.
  assign w_rem_after = r_remain - f_den(r_sel);

  // State and registered outputs.
  always_ff @(posedge CLK or posedge RD) begin
    if (RD) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_req    <= 1'b0;
      r_sel    <= 2'b00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_remain <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_req    <= w_req_nxt;
      r_sel    <= w_sel_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_remain <= w_remain_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_req_nxt    = r_req;
    w_sel_nxt    = r_sel;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_err_nxt    = r_err;
    w_remain_nxt = r_remain;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (ACT_IN) begin
          w_cnt_nxt = '0;
          if (CHANGE_IN == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_remain_nxt = CHANGE_IN;
            w_busy_nxt   = 1'b1;
            w_req_nxt    = 1'b1;
            w_sel_nxt    = f_sel(CHANGE_IN);
            w_timer_nxt  = TO_LOAD;
            w_state_nxt  = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (COIN_ACK) begin
          w_remain_nxt = w_rem_after;
          w_cnt_nxt    = r_cnt + WIDTH'(1);
          w_req_nxt    = 1'b0;
          if (w_rem_after != '0) begin
            w_state_nxt = S_GAP;
          end else begin
            w_state_nxt = S_FIN;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_sel_nxt   = 2'b00;
          end
        end else if (r_timer == '0) begin
          w_state_nxt = S_ERR;
          w_err_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_req_nxt   = 1'b0;
          w_sel_nxt   = 2'b00;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      S_GAP: begin
        w_sel_nxt   = f_sel(r_remain);
        w_req_nxt   = 1'b1;
        w_timer_nxt = TO_LOAD;
        w_state_nxt = S_REQ;
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign COIN_REQ = r_req;
  assign COIN_SEL = r_sel;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign ERR      = r_err;
  assign REMAIN   = r_remain;
  assign COIN_CNT = r_cnt;

endmodule
